act_expand_buffer: RTL and testbench

- Consumes the narrow activation words produced by the activation (ReLU) stage: 1-bit sign, 5-bit exponent, 6-bit mantissa.
- Widens each word back to the neuron-input float format (1-bit sign, 6-bit exponent, 12-bit mantissa) for the next layer's multiply-accumulate.
- Buffers words in a small FIFO and delivers them over a valid/ready handshake, marking the last element of each activation vector.

---
 rtl/act_expand_buffer_pkg.sv | 32 +++
 rtl/act_sync_fifo.sv | 66 ++++++
 rtl/act_expand_buffer.sv | 84 ++++++++
 tb/tb_act_expand_buffer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/act_expand_buffer_pkg.sv
// Neuron float formats shared by the activation-to-MAC path.
// The narrow ReLU output word is widened here into the neuron-input float format.
package act_expand_buffer_pkg;

  localparam int NARROW_EXP_W = 5;
  localparam int NARROW_MAN_W = 6;
  localparam int WIDE_EXP_W   = 6;
  localparam int WIDE_MAN_W   = 12;
  localparam int MAN_PAD_W    = 6;
  localparam int WIDE_W       = 1 + WIDE_EXP_W + WIDE_MAN_W;

  typedef struct packed {
    logic                  sign;
    logic [WIDE_EXP_W-1:0] exp;
    logic [WIDE_MAN_W-1:0] mant;
  } wide_word_t;

  // A zero exponent with a zero mantissa is a signed zero; it is folded to +0.
  function automatic wide_word_t widen(input logic                    sign,
                                       input logic [NARROW_EXP_W-1:0] exp,
                                       input logic [NARROW_MAN_W-1:0] mant);
    wide_word_t w;
    w = '0;
    if ((exp != '0) || (mant != '0)) begin
      w.sign = sign;
      w.exp  = {1'b0, exp};
      w.mant = {mant, {MAN_PAD_W{1'b0}}};
    end
    return w;
  endfunction

endpackage

// File: rtl/act_sync_fifo.sv
// Generic single-clock FIFO with registered occupancy; the head entry is read
// combinationally so data appears the cycle after it is written.
module act_sync_fifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 4
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wrData,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdData,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FullLevel = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q;
  logic [AW-1:0]    rdPtr_q;
  logic [AW:0]      level_q;
  logic [AW:0]      level_d;
  logic             doPush;
  logic             doPop;

  assign full   = (level_q == FullLevel);
  assign empty  = (level_q == '0);
  assign level  = level_q;
  assign rdData = mem_q[rdPtr_q];
  assign doPush = push && !full;
  assign doPop  = pop && !empty;

  always_comb begin
    level_d = level_q;
    case ({doPush, doPop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Storage is cleared on reset so the head reads as zero while empty.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
    end else begin
      if (doPush) begin
        mem_q[wrPtr_q] <= wrData;
        wrPtr_q        <= wrPtr_q + 1'b1;
      end
      if (doPop) begin
        rdPtr_q <= rdPtr_q + 1'b1;
      end
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/act_expand_buffer.sv
// Widens narrow activation words on write, buffers them, and tags the last
// element of each activation vector on the output handshake.
module act_expand_buffer
  import act_expand_buffer_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int VECTOR_LEN = 16
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic                      InValid,
  output logic                      InReady,
  input  logic                      InSign,
  input  logic [NARROW_EXP_W-1:0]   InExponent,
  input  logic [NARROW_MAN_W-1:0]   InMantissa,
  output logic                      OutValid,
  input  logic                      OutReady,
  output logic                      OutSign,
  output logic [WIDE_EXP_W-1:0]     OutExponent,
  output logic [WIDE_MAN_W-1:0]     OutMantissa,
  output logic                      OutLast,
  output logic [$clog2(DEPTH):0]    Level
);

  localparam int CntW = (VECTOR_LEN > 1) ? $clog2(VECTOR_LEN) : 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(VECTOR_LEN - 1);

  wide_word_t      wrWord;
  wide_word_t      headWord;
  logic [WIDE_W-1:0] headBits;
  logic            full;
  logic            empty;
  logic            pushEn;
  logic            popEn;
  logic            lastElem;
  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;

  assign wrWord   = widen(InSign, InExponent, InMantissa);
  assign InReady  = !full;
  assign OutValid = !empty;
  assign pushEn   = InValid && InReady;
  assign popEn    = OutValid && OutReady;

  act_sync_fifo #(
    .WIDTH (WIDE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .Clock  (Clock),
    .Reset  (Reset),
    .push   (pushEn),
    .wrData (wrWord),
    .pop    (popEn),
    .rdData (headBits),
    .full   (full),
    .empty  (empty),
    .level  (Level)
  );

  assign headWord    = headBits;
  assign OutSign     = headWord.sign;
  assign OutExponent = headWord.exp;
  assign OutMantissa = headWord.mant;

  // Counts completed output transfers within the current vector.
  assign lastElem = (cnt_q == LastIdx);
  assign OutLast  = OutValid && lastElem;

  always_comb begin
    cnt_d = cnt_q;
    if (popEn) begin
      cnt_d = lastElem ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_act_expand_buffer.sv
// Scoreboard bench: stimulus queues hand-computed wide words, a negedge monitor
// pops and compares them on every output transfer.
module tb_act_expand_buffer;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        InValid = 1'b0;
  logic        InSign = 1'b0;
  logic [4:0]  InExponent = '0;
  logic [5:0]  InMantissa = '0;
  logic        OutReady = 1'b0;
  logic        InReady;
  logic        OutValid;
  logic        OutSign;
  logic [5:0]  OutExponent;
  logic [11:0] OutMantissa;
  logic        OutLast;
  logic [2:0]  Level;

  logic        InReady1;
  logic        OutValid1;
  logic        OutSign1;
  logic [5:0]  OutExponent1;
  logic [11:0] OutMantissa1;
  logic        OutLast1;
  logic [1:0]  Level1;

  typedef struct packed {
    logic [18:0] data;
    logic        last;
  } expect_t;

  expect_t expQ[$];
  int      checks = 0;
  int      errors = 0;
  int      pushIdx = 0;
  bit      streamDone = 1'b0;

  act_expand_buffer #(.DEPTH(4), .VECTOR_LEN(16)) dut (
    .Clock(Clock), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .InSign(InSign), .InExponent(InExponent), .InMantissa(InMantissa),
    .OutValid(OutValid), .OutReady(OutReady), .OutSign(OutSign),
    .OutExponent(OutExponent), .OutMantissa(OutMantissa),
    .OutLast(OutLast), .Level(Level)
  );

  act_expand_buffer #(.DEPTH(2), .VECTOR_LEN(1)) dutOne (
    .Clock(Clock), .Reset(Reset), .InValid(InValid), .InReady(InReady1),
    .InSign(InSign), .InExponent(InExponent), .InMantissa(InMantissa),
    .OutValid(OutValid1), .OutReady(OutReady), .OutSign(OutSign1),
    .OutExponent(OutExponent1), .OutMantissa(OutMantissa1),
    .OutLast(OutLast1), .Level(Level1)
  );

  always #5 Clock = ~Clock;

  function automatic logic [18:0] wideOf(input logic s, input logic [5:0] e, input logic [11:0] m);
    return {s, e, m};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
    end
  endtask

  // Holds the word on the input until the buffer accepts it, then queues its expectation.
  task automatic applyStimulus(input logic s, input logic [4:0] e, input logic [5:0] m,
                               input logic [18:0] expWide);
    bit accepted;
    int waited;
    accepted = 1'b0;
    waited   = 0;
    InValid    = 1'b1;
    InSign     = s;
    InExponent = e;
    InMantissa = m;
    while (!accepted && waited < 200) begin
      @(negedge Clock);
      if (InReady) begin
        accepted = 1'b1;
        expQ.push_back('{data: expWide, last: ((pushIdx % 16) == 15)});
        pushIdx++;
      end
      @(posedge Clock);
      #1;
      waited++;
    end
    InValid = 1'b0;
    if (!accepted) checkOutput("pushTimeout", 32'd0, 32'd1);
  endtask

  task automatic applyReset(input int n);
    Reset = 1'b1;
    repeat (n) @(posedge Clock);
    #1;
    Reset = 1'b0;
    expQ.delete();
    pushIdx = 0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 500) begin
      @(negedge Clock);
      n++;
    end
    if (expQ.size() != 0) checkOutput("drainTimeout", expQ.size(), 0);
    @(posedge Clock);
    @(negedge Clock);
    checkOutput("levelAfterDrain", Level, 0);
    @(posedge Clock);
    #1;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "OutValid"}, OutValid, 0);
    checkOutput({tag, "InReady"}, InReady, 1);
    checkOutput({tag, "Level"}, Level, 0);
    checkOutput({tag, "OutLast"}, OutLast, 0);
    checkOutput({tag, "OutData"}, {OutSign, OutExponent, OutMantissa}, 0);
  endtask

  task automatic streamWord(input int i);
    logic       s;
    logic [4:0] e;
    logic [5:0] m;
    s = 1'(i % 2);
    e = 5'((i % 31) + 1);
    m = 6'(i * 5 + 3);
    applyStimulus(s, e, m, wideOf(s, {1'b0, e}, {m, 6'b000000}));
  endtask

  // Scoreboard monitor: every output transfer must match the oldest expectation.
  always @(negedge Clock) begin
    if (!Reset && OutValid && OutReady) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedOutput", {OutSign, OutExponent, OutMantissa}, 32'h7FFFFFFF);
      end else begin
        expect_t e;
        e = expQ.pop_front();
        checkOutput("outData", {OutSign, OutExponent, OutMantissa}, e.data);
        checkOutput("outLast", OutLast, e.last);
      end
    end
  end

  // With a one-element vector every valid word is a last element.
  always @(negedge Clock) begin
    if (!Reset && OutValid1) checkOutput("lastEveryWord", OutLast1, 1);
  end

  initial begin
    repeat (2) @(posedge Clock);
    #1;
    Reset = 1'b0;
    @(negedge Clock);
    checkResetState("reset");
    @(posedge Clock);
    #1;

    OutReady = 1'b1;
    applyStimulus(1'b1, 5'b10011, 6'b101101, wideOf(1'b1, 6'b010011, 12'b101101000000));
    @(negedge Clock);
    checkOutput("firstLatencyValid", OutValid, 1);
    waitDrain();

    applyStimulus(1'b1, 5'b00000, 6'b000000, 19'd0);
    applyStimulus(1'b0, 5'b00000, 6'b000001, wideOf(1'b0, 6'h00, 12'h040));
    waitDrain();

    OutReady = 1'b0;
    fork
      begin
        applyStimulus(1'b0, 5'h01, 6'h01, wideOf(1'b0, 6'h01, 12'h040));
        applyStimulus(1'b1, 5'h1F, 6'h3F, wideOf(1'b1, 6'h1F, 12'hFC0));
        applyStimulus(1'b0, 5'h0A, 6'h15, wideOf(1'b0, 6'h0A, 12'h540));
        applyStimulus(1'b1, 5'h00, 6'h20, wideOf(1'b1, 6'h00, 12'h800));
        applyStimulus(1'b0, 5'h10, 6'h00, wideOf(1'b0, 6'h10, 12'h000));
      end
      begin
        repeat (8) @(posedge Clock);
        @(negedge Clock);
        checkOutput("fullLevel", Level, 4);
        checkOutput("fullInReady", InReady, 0);
        checkOutput("fullOutValid", OutValid, 1);
        @(posedge Clock);
        #1;
        OutReady = 1'b1;
      end
    join
    waitDrain();

    applyReset(2);
    OutReady = 1'b1;
    for (int i = 0; i < 33; i++) streamWord(i);
    waitDrain();

    applyReset(1);
    streamDone = 1'b0;
    fork
      begin
        for (int i = 0; i < 33; i++) streamWord(i + 40);
        streamDone = 1'b1;
      end
      begin
        while (!streamDone) begin
          @(posedge Clock);
          #1;
          OutReady = 1'($urandom_range(0, 1));
        end
      end
    join
    OutReady = 1'b1;
    waitDrain();

    // Leave the vector counter mid-vector before the mid-stream reset.
    applyStimulus(1'b0, 5'h03, 6'h07, wideOf(1'b0, 6'h03, 12'h1C0));
    waitDrain();
    OutReady = 1'b0;
    for (int i = 0; i < 3; i++) streamWord(i + 80);
    @(negedge Clock);
    checkOutput("midLevel", Level, 3);
    @(posedge Clock);
    #1;
    applyReset(1);
    @(negedge Clock);
    checkResetState("midReset");
    @(posedge Clock);
    #1;
    OutReady = 1'b1;
    for (int i = 0; i < 16; i++) streamWord(i + 100);
    waitDrain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
